i2c_slave_mem: RTL and testbench

I2C_SLAVE_MEM -- requirements
Module: i2c_slave_mem

---
 rtl/i2c_pkg.sv | 21 ++
 rtl/i2c_bus_sync.sv | 44 ++++
 rtl/i2c_slave_mem.sv | 255 +++++++++++++++++++++++++
 tb/tb_i2c_slave_mem.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C register-file slave.
// Contents: slave state encoding, default device address, ACK/NACK bit levels.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    DEV_ADDR  = 4'd1,
    DEV_ACK   = 4'd2,
    WORD_ADDR = 4'd3,
    WORD_ACK  = 4'd4,
    WR_DATA   = 4'd5,
    WR_ACK    = 4'd6,
    RD_DATA   = 4'd7,
    RD_ACK    = 4'd8
  } i2c_state_e;

  localparam logic [6:0] DEFAULT_SLAVE_ADDR = 7'h50;
  localparam logic       ACK_BIT            = 1'b0;
  localparam logic       NACK_BIT           = 1'b1;

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronises the asynchronous SCL/SDA pins into the clk domain and derives
// bus events from the synchronised levels.
// Ports:
//   clk, rst_in         system clock, synchronous active-high reset
//   scl_in, sda_in      raw pin levels
//   scl_rise, scl_fall  one-clk pulses on synchronised SCL edges
//   start_det, stop_det one-clk pulses on START / STOP conditions
//   sda_s               synchronised SDA level
module i2c_bus_sync (
  input  logic clk,
  input  logic rst_in,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  // Bit 0: metastability flop, bit 1: synchronised level, bit 2: previous level.
  logic [2:0] scl_pipe_r;
  logic [2:0] sda_pipe_r;

  // Pin synchroniser and edge history; resets to the idle-high bus level so
  // leaving reset cannot look like a START.
  always_ff @(posedge clk) begin
    if (rst_in) begin
      scl_pipe_r <= 3'b111;
      sda_pipe_r <= 3'b111;
    end else begin
      scl_pipe_r <= {scl_pipe_r[1:0], scl_in};
      sda_pipe_r <= {sda_pipe_r[1:0], sda_in};
    end
  end

  assign scl_rise  = scl_pipe_r[1] & ~scl_pipe_r[2];
  assign scl_fall  = ~scl_pipe_r[1] & scl_pipe_r[2];
  // SCL must be high both before and after the SDA transition.
  assign start_det = scl_pipe_r[1] & scl_pipe_r[2] & sda_pipe_r[2] & ~sda_pipe_r[1];
  assign stop_det  = scl_pipe_r[1] & scl_pipe_r[2] & ~sda_pipe_r[2] & sda_pipe_r[1];
  assign sda_s     = sda_pipe_r[1];

endmodule

// File: rtl/i2c_slave_mem.sv
// I2C slave exposing DEPTH byte registers with an auto-incrementing pointer.
// Ports:
//   clk, rst_in  system clock, synchronous active-high reset
//   scl_in       SCL pin level (asynchronous)
//   sda_in       SDA pin level (asynchronous)
//   sda_oe       1 pulls SDA low through the external open-drain buffer
//   busy         high while an addressed transaction is in progress
//   wr_strobe    one-clk pulse when a data byte is committed
//   wr_index     register index of the last committed write
module i2c_slave_mem
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = DEFAULT_SLAVE_ADDR,
  parameter int         DEPTH      = 16
) (
  input  logic                     clk,
  input  logic                     rst_in,
  input  logic                     scl_in,
  input  logic                     sda_in,
  output logic                     sda_oe,
  output logic                     busy,
  output logic                     wr_strobe,
  output logic [$clog2(DEPTH)-1:0] wr_index
);

  localparam int AW = $clog2(DEPTH);

  logic scl_rise, scl_fall, start_det, stop_det, sda_s;

  i2c_state_e state_r, state_s;
  logic [3:0]    bit_cnt_r, bit_cnt_s;
  logic [7:0]    shift_r, shift_s;
  logic [AW-1:0] pointer_r, pointer_s;
  logic          sda_oe_r, sda_oe_s;
  logic          busy_r, busy_s;
  logic          wr_strobe_r;
  logic [AW-1:0] wr_index_r;
  logic          wr_en_s;
  logic [7:0]    rx_byte_s;
  logic [7:0]    rd_byte_s;
  logic [7:0]    regs_r [DEPTH];

  i2c_bus_sync u_bus_sync (
    .clk       (clk),
    .rst_in    (rst_in),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_s     (sda_s)
  );

  // Next-state, pointer, shift register and SDA drive decisions.
  always_comb begin
    state_s   = state_r;
    bit_cnt_s = bit_cnt_r;
    shift_s   = shift_r;
    pointer_s = pointer_r;
    sda_oe_s  = sda_oe_r;
    wr_en_s   = 1'b0;
    rx_byte_s = {shift_r[6:0], sda_s};
    rd_byte_s = regs_r[pointer_r];

    if (start_det) begin
      state_s   = DEV_ADDR;
      bit_cnt_s = 4'd0;
      shift_s   = 8'h00;
      sda_oe_s  = 1'b0;
    end else if (stop_det) begin
      state_s   = IDLE;
      bit_cnt_s = 4'd0;
      sda_oe_s  = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          sda_oe_s = 1'b0;
        end
        DEV_ADDR: begin
          if (scl_rise) begin
            shift_s = rx_byte_s;
            if (bit_cnt_r == 4'd7) begin
              bit_cnt_s = 4'd0;
              if (rx_byte_s[7:1] == SLAVE_ADDR) begin
                state_s = DEV_ACK;
              end else begin
                state_s = IDLE;
              end
            end else begin
              bit_cnt_s = bit_cnt_r + 4'd1;
            end
          end else begin
            shift_s = shift_r;
          end
        end
        WORD_ADDR: begin
          if (scl_rise) begin
            shift_s = rx_byte_s;
            if (bit_cnt_r == 4'd7) begin
              bit_cnt_s = 4'd0;
              pointer_s = rx_byte_s[AW-1:0];
              state_s   = WORD_ACK;
            end else begin
              bit_cnt_s = bit_cnt_r + 4'd1;
            end
          end else begin
            shift_s = shift_r;
          end
        end
        WR_DATA: begin
          if (scl_rise) begin
            shift_s = rx_byte_s;
            if (bit_cnt_r == 4'd7) begin
              bit_cnt_s = 4'd0;
              wr_en_s   = 1'b1;
              pointer_s = pointer_r + AW'(1);
              state_s   = WR_ACK;
            end else begin
              bit_cnt_s = bit_cnt_r + 4'd1;
            end
          end else begin
            shift_s = shift_r;
          end
        end
        // ACK phases: sda_oe is still low at the 8th SCL fall, so the first
        // fall seen here starts the ACK and the second one ends it.
        DEV_ACK: begin
          if (scl_fall) begin
            if (!sda_oe_r) begin
              sda_oe_s = ~ACK_BIT;
            end else begin
              bit_cnt_s = 4'd0;
              if (shift_r[0]) begin
                // Read: first data bit goes out on the same fall that ends the ACK.
                state_s  = RD_DATA;
                shift_s  = rd_byte_s;
                sda_oe_s = ~rd_byte_s[7];
              end else begin
                state_s  = WORD_ADDR;
                sda_oe_s = 1'b0;
              end
            end
          end else begin
            sda_oe_s = sda_oe_r;
          end
        end
        WORD_ACK, WR_ACK: begin
          if (scl_fall) begin
            if (!sda_oe_r) begin
              sda_oe_s = ~ACK_BIT;
            end else begin
              sda_oe_s  = 1'b0;
              bit_cnt_s = 4'd0;
              state_s   = WR_DATA;
            end
          end else begin
            sda_oe_s = sda_oe_r;
          end
        end
        // bit_cnt counts master sampling edges; after the 8th, release SDA.
        RD_DATA: begin
          if (scl_rise) begin
            bit_cnt_s = bit_cnt_r + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_r == 4'd8) begin
              sda_oe_s  = 1'b0;
              bit_cnt_s = 4'd0;
              state_s   = RD_ACK;
            end else begin
              shift_s  = {shift_r[6:0], shift_r[7]};
              sda_oe_s = ~shift_r[6];
            end
          end else begin
            sda_oe_s = sda_oe_r;
          end
        end
        // bit_cnt = 1 marks a master ACK seen; the next byte loads on the fall.
        RD_ACK: begin
          if (scl_rise) begin
            if (sda_s == NACK_BIT) begin
              state_s  = IDLE;
              sda_oe_s = 1'b0;
            end else begin
              pointer_s = pointer_r + AW'(1);
              bit_cnt_s = 4'd1;
            end
          end else if (scl_fall && (bit_cnt_r == 4'd1)) begin
            state_s   = RD_DATA;
            bit_cnt_s = 4'd0;
            shift_s   = rd_byte_s;
            sda_oe_s  = ~rd_byte_s[7];
          end else begin
            sda_oe_s = sda_oe_r;
          end
        end
        default: begin
          state_s  = IDLE;
          sda_oe_s = 1'b0;
        end
      endcase
    end

    // A repeated START keeps busy as it was; a fresh one waits for the match.
    if (state_s == IDLE) begin
      busy_s = 1'b0;
    end else if (state_s == DEV_ADDR) begin
      busy_s = busy_r;
    end else begin
      busy_s = 1'b1;
    end
  end

  // Control state, pointer and registered outputs.
  always_ff @(posedge clk) begin
    if (rst_in) begin
      state_r     <= IDLE;
      bit_cnt_r   <= 4'd0;
      shift_r     <= 8'h00;
      pointer_r   <= {AW{1'b0}};
      sda_oe_r    <= 1'b0;
      busy_r      <= 1'b0;
      wr_strobe_r <= 1'b0;
      wr_index_r  <= {AW{1'b0}};
    end else begin
      state_r     <= state_s;
      bit_cnt_r   <= bit_cnt_s;
      shift_r     <= shift_s;
      pointer_r   <= pointer_s;
      sda_oe_r    <= sda_oe_s;
      busy_r      <= busy_s;
      wr_strobe_r <= wr_en_s;
      if (wr_en_s) begin
        wr_index_r <= pointer_r;
      end
    end
  end

  // Register file; a byte commits on the 8th SCL rise of a data byte.
  always_ff @(posedge clk) begin
    if (rst_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_r[i] <= 8'h00;
      end
    end else if (wr_en_s) begin
      regs_r[pointer_r] <= rx_byte_s;
    end
  end

  assign sda_oe    = sda_oe_r;
  assign busy      = busy_r;
  assign wr_strobe = wr_strobe_r;
  assign wr_index  = wr_index_r;

endmodule

// File: tb/tb_i2c_slave_mem.sv
// Directed bench for i2c_slave_mem: a bit-banged I2C master with an
// open-drain bus model. Expected ACKs, read bytes and write indices go into
// queues when stimulus is driven and are popped when the DUT answers.
module tb_i2c_slave_mem;
  import i2c_pkg::*;

  logic       clk = 1'b0;
  logic       rst_in = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_line;
  logic       sda_oe, busy, wr_strobe;
  logic [3:0] wr_index;

  int n_checks = 0;
  int n_fail   = 0;
  int oe_cycles = 0;
  int oe_bad    = 0;
  logic oe_prev = 1'b0;

  logic       exp_ack_q [$];
  logic [7:0] exp_q     [$];
  logic [3:0] exp_wr_q  [$];
  logic [3:0] obs_wr_q  [$];

  assign sda_line = sda_m & ~sda_oe;

  i2c_slave_mem dut (
    .clk       (clk),
    .rst_in    (rst_in),
    .scl_in    (scl_m),
    .sda_in    (sda_line),
    .sda_oe    (sda_oe),
    .busy      (busy),
    .wr_strobe (wr_strobe),
    .wr_index  (wr_index)
  );

  always #5 clk = ~clk;

  // Bus monitor on the falling clk edge, away from DUT updates.
  always @(negedge clk) begin
    if (!rst_in) begin
      if (wr_strobe) obs_wr_q.push_back(wr_index);
      if (sda_oe) oe_cycles++;
      if ((sda_oe !== oe_prev) && scl_m) oe_bad++;
    end
    oe_prev = sda_oe;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic i2c_start();
    if (scl_m == 1'b0) begin
      tick(5); sda_m = 1'b1; tick(5); scl_m = 1'b1;
    end
    tick(5); sda_m = 1'b0; tick(5); scl_m = 1'b0;
  endtask

  task automatic i2c_stop();
    tick(5); sda_m = 1'b0; tick(5); scl_m = 1'b1; tick(5); sda_m = 1'b1; tick(10);
  endtask

  task automatic write_bit(input logic b);
    tick(5); sda_m = b; tick(5); scl_m = 1'b1; tick(10); scl_m = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input logic exp_ack, input string tag);
    logic obs;
    exp_ack_q.push_back(exp_ack);
    for (int i = 7; i >= 0; i--) write_bit(b[i]);
    tick(5); sda_m = 1'b1; tick(5); scl_m = 1'b1; tick(5); #1;
    obs = sda_line;
    check(tag, obs, exp_ack_q.pop_front());
    tick(5); scl_m = 1'b0;
  endtask

  task automatic recv(input logic [7:0] exp, input logic ack, input string tag);
    logic [7:0] d = 8'h00;
    exp_q.push_back(exp);
    for (int i = 0; i < 8; i++) begin
      tick(5); sda_m = 1'b1; tick(5); scl_m = 1'b1; tick(5); #1;
      d = {d[6:0], sda_line};
      tick(5); scl_m = 1'b0;
    end
    tick(5); sda_m = ack; tick(5); scl_m = 1'b1; tick(10); scl_m = 1'b0;
    check(tag, d, exp_q.pop_front());
  endtask

  task automatic check_wr(input string tag);
    check({tag, "_count"}, obs_wr_q.size(), exp_wr_q.size());
    while ((obs_wr_q.size() > 0) && (exp_wr_q.size() > 0))
      check({tag, "_index"}, obs_wr_q.pop_front(), exp_wr_q.pop_front());
    obs_wr_q.delete();
    exp_wr_q.delete();
  endtask

  initial begin
    int oe_before;

    // Reset state
    tick(3); #1;
    check("rst_sda_oe", sda_oe, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_wr_strobe", wr_strobe, 1'b0);
    check("rst_wr_index", wr_index, 4'd0);
    check("rst_state", dut.state_r, IDLE);
    rst_in = 1'b0;
    tick(20);

    // Write A5, 5A starting at word 3
    i2c_start();
    send(8'hA0, 1'b0, "w1_dev");
    send(8'h03, 1'b0, "w1_word");
    exp_wr_q.push_back(4'd3); send(8'hA5, 1'b0, "w1_d0");
    exp_wr_q.push_back(4'd4); send(8'h5A, 1'b0, "w1_d1");
    tick(2); #1;
    check("w1_busy", busy, 1'b1);
    i2c_stop(); #1;
    check("w1_busy_after", busy, 1'b0);
    check_wr("w1_wr");

    // Random read with repeated START
    i2c_start();
    send(8'hA0, 1'b0, "r1_dev");
    send(8'h03, 1'b0, "r1_word");
    i2c_start();
    send(8'hA1, 1'b0, "r1_devr");
    recv(8'hA5, 1'b0, "r1_d0");
    recv(8'h5A, 1'b1, "r1_d1");
    i2c_stop(); #1;
    check("r1_pointer", dut.pointer_r, 4'd4);

    // Current-address read continues from the pointer
    i2c_start();
    send(8'hA1, 1'b0, "r2_devr");
    recv(8'h5A, 1'b1, "r2_d0");
    i2c_stop();

    // Wrong device address: never drives SDA, never writes
    oe_before = oe_cycles;
    i2c_start();
    send(8'hA4, 1'b1, "na_dev");
    send(8'h03, 1'b1, "na_word");
    send(8'hFF, 1'b1, "na_data");
    i2c_stop(); #1;
    check("na_oe_cycles", oe_cycles - oe_before, 0);
    check("na_busy", busy, 1'b0);
    check_wr("na_wr");

    // Pointer wrap on write, upper word bits ignored
    i2c_start();
    send(8'hA0, 1'b0, "wrap_dev");
    send(8'h0F, 1'b0, "wrap_word");
    exp_wr_q.push_back(4'd15); send(8'h11, 1'b0, "wrap_d0");
    exp_wr_q.push_back(4'd0);  send(8'h22, 1'b0, "wrap_d1");
    i2c_stop();
    i2c_start();
    send(8'hA0, 1'b0, "hi_dev");
    send(8'h1F, 1'b0, "hi_word");
    exp_wr_q.push_back(4'd15); send(8'h33, 1'b0, "hi_d0");
    i2c_stop();
    check_wr("wrap_wr");
    // Read back across the wrap
    i2c_start();
    send(8'hA0, 1'b0, "rw_dev");
    send(8'h0F, 1'b0, "rw_word");
    i2c_start();
    send(8'hA1, 1'b0, "rw_devr");
    recv(8'h33, 1'b0, "rw_r15");
    recv(8'h22, 1'b0, "rw_r0");
    recv(8'h00, 1'b1, "rw_r1");
    i2c_stop();

    // STOP after 4 data bits: discarded, pointer unchanged
    i2c_start();
    send(8'hA0, 1'b0, "pt_dev");
    send(8'h05, 1'b0, "pt_word");
    write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b0);
    i2c_stop(); #1;
    check_wr("pt_wr");
    check("pt_pointer", dut.pointer_r, 4'd5);
    i2c_start();
    send(8'hA0, 1'b0, "nx_dev");
    send(8'h05, 1'b0, "nx_word");
    exp_wr_q.push_back(4'd5); send(8'h77, 1'b0, "nx_d0");
    i2c_stop();
    check_wr("nx_wr");
    i2c_start();
    send(8'hA0, 1'b0, "nr_dev");
    send(8'h05, 1'b0, "nr_word");
    i2c_start();
    send(8'hA1, 1'b0, "nr_devr");
    recv(8'h77, 1'b1, "nr_r5");
    i2c_stop();
    // Registers 3/4 untouched by the wrong-address transfer
    i2c_start();
    send(8'hA0, 1'b0, "ck_dev");
    send(8'h03, 1'b0, "ck_word");
    i2c_start();
    send(8'hA1, 1'b0, "ck_devr");
    recv(8'hA5, 1'b0, "ck_r3");
    recv(8'h5A, 1'b1, "ck_r4");
    i2c_stop();

    // Reset while the slave drives a 0 data bit
    i2c_start();
    send(8'hA0, 1'b0, "rr_dev");
    send(8'h01, 1'b0, "rr_word");
    i2c_start();
    send(8'hA1, 1'b0, "rr_devr");
    tick(5); #1;
    check("rr_driving", sda_oe, 1'b1);
    tick(1);
    rst_in = 1'b1;
    tick(1); #1;
    check("rr_sda_oe", sda_oe, 1'b0);
    check("rr_state", dut.state_r, IDLE);
    check("rr_busy", busy, 1'b0);
    for (int i = 0; i < 16; i++) check($sformatf("rr_reg%0d", i), dut.regs_r[i], 8'h00);
    rst_in = 1'b0;
    i2c_stop();
    i2c_start();
    send(8'hA0, 1'b0, "pr_dev");
    send(8'h03, 1'b0, "pr_word");
    i2c_start();
    send(8'hA1, 1'b0, "pr_devr");
    recv(8'h00, 1'b1, "pr_r3");
    i2c_stop();
    check_wr("end_wr");
    check("oe_change_scl_high", oe_bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
